// File: rtl/dtree_seq_if.sv
// Handshake and configuration bundle for the decision-tree sequencer.
// master drives features/config and consumes results; slave is the sequencer.
interface dtree_seq_if #(
  parameter int unsigned AW = 6
);
  localparam int unsigned NW = 12 + 2 * AW;

  logic [7:0]    X0;
  logic [7:0]    X1;
  logic [7:0]    X2;
  logic [7:0]    X3;
  logic [7:0]    X4;
  logic [7:0]    X5;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    out;
  logic          out_err;
  logic          out_valid;
  logic          out_ready;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [NW-1:0] cfg_wdata;
  logic          cfg_rej;

  modport master (
    output X0, X1, X2, X3, X4, X5, in_valid, out_ready, cfg_we, cfg_addr, cfg_wdata,
    input  in_ready, out, out_err, out_valid, cfg_rej
  );

  modport slave (
    input  X0, X1, X2, X3, X4, X5, in_valid, out_ready, cfg_we, cfg_addr, cfg_wdata,
    output in_ready, out, out_err, out_valid, cfg_rej
  );
endinterface

// File: rtl/dtree_seq_ctrl.sv
// Decision-tree classifier: walks a register-based node table one node per cycle
// using a single shared 8-bit comparator, with step-limit and bad-feature aborts.
module dtree_seq_ctrl #(
  parameter int unsigned AW        = 6,
  parameter int unsigned MAX_STEPS = 16
) (
  input logic        clk,
  input logic        rst,
  dtree_seq_if.slave bus
);
  localparam int unsigned NW    = 12 + 2 * AW;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned SW    = $clog2(MAX_STEPS + 1);

  typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

  state_t        state;
  logic [NW-1:0] node_tab [DEPTH];
  logic [7:0]    feat_q   [6];
  logic [AW-1:0] ptr;
  logic [SW-1:0] steps;

  logic [NW-1:0] node_c;
  logic          leaf_c;
  logic [2:0]    fidx_c;
  logic [7:0]    thr_c;
  logic [AW-1:0] left_c;
  logic [AW-1:0] right_c;
  logic [7:0]    fval_c;
  logic          go_left_c;
  logic [SW-1:0] steps_inc_c;

  // Decode the current node and run the shared comparator
  always_comb begin
    node_c      = node_tab[ptr];
    leaf_c      = node_c[0];
    fidx_c      = node_c[3:1];
    thr_c       = node_c[11:4];
    left_c      = node_c[11+AW:12];
    right_c     = node_c[11+2*AW:12+AW];
    steps_inc_c = steps + SW'(1);
    case (fidx_c)
      3'd0:    fval_c = feat_q[0];
      3'd1:    fval_c = feat_q[1];
      3'd2:    fval_c = feat_q[2];
      3'd3:    fval_c = feat_q[3];
      3'd4:    fval_c = feat_q[4];
      3'd5:    fval_c = feat_q[5];
      default: fval_c = 8'd0;
    endcase
    go_left_c = (fval_c <= thr_c);
  end

  // Node table survives reset; writes only land while idle
  always_ff @(posedge clk) begin
    if (bus.cfg_we && (state == IDLE)) begin
      node_tab[bus.cfg_addr] <= bus.cfg_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= '0;
      steps         <= '0;
      bus.in_ready  <= 1'b1;
      bus.out       <= 2'd0;
      bus.out_err   <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.cfg_rej   <= 1'b0;
    end else begin
      bus.cfg_rej <= bus.cfg_we && (state != IDLE);
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            feat_q[0]    <= bus.X0;
            feat_q[1]    <= bus.X1;
            feat_q[2]    <= bus.X2;
            feat_q[3]    <= bus.X3;
            feat_q[4]    <= bus.X4;
            feat_q[5]    <= bus.X5;
            ptr          <= '0;
            steps        <= '0;
            bus.in_ready <= 1'b0;
            state        <= WALK;
          end
        end
        WALK: begin
          if (leaf_c) begin
            bus.out     <= node_c[5:4];
            bus.out_err <= 1'b0;
            state       <= DONE;
          end else if (fidx_c > 3'd5 || steps_inc_c == SW'(MAX_STEPS)) begin
            // Bad feature select or the step budget is exhausted on this internal node
            bus.out     <= 2'd0;
            bus.out_err <= 1'b1;
            state       <= DONE;
          end else begin
            ptr   <= go_left_c ? left_c : right_c;
            steps <= steps_inc_c;
          end
        end
        DONE: begin
          // out_valid rises one cycle after entering DONE, then waits for the consumer
          if (!bus.out_valid) begin
            bus.out_valid <= 1'b1;
          end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dtree_seq_ctrl.sv
// Bench for dtree_seq_ctrl: table-walking reference model checked every cycle,
// plus directed vectors with hand-computed classes and latencies.
module tb_dtree_seq_ctrl;
  localparam int unsigned AW        = 6;
  localparam int unsigned NW        = 12 + 2 * AW;
  localparam int unsigned MAX_STEPS = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dtree_seq_if #(.AW(AW)) bus ();

  dtree_seq_ctrl #(.AW(AW), .MAX_STEPS(MAX_STEPS)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [NW-1:0] mk_int(input int f, input int thr, input int l, input int r);
    return {AW'(r), AW'(l), 8'(thr), 3'(f), 1'b0};
  endfunction

  function automatic logic [NW-1:0] mk_leaf(input int c);
    return {(NW-6)'(0), 2'(c), 3'd0, 1'b1};
  endfunction

  function automatic logic [47:0] vec(input int x0, input int x1, input int x5);
    return {8'(x5), 8'd0, 8'd0, 8'd0, 8'(x1), 8'(x0)};
  endfunction

  // Reference model: a shadow table and a plain walk of the tree
  logic [NW-1:0] mtab [1 << AW];
  logic [7:0]    xs   [8];
  logic          busy    = 1'b0;
  logic          started = 1'b0;
  logic          rej_e   = 1'b0;
  logic [1:0]    cls_e   = 2'd0;
  logic          err_e   = 1'b0;
  int            lat_e   = 0;
  int            hs      = 0;
  int            cyc     = 0;

  function automatic void model_run(output logic [1:0] cls, output logic err, output int lat);
    logic [AW-1:0] p;
    logic [NW-1:0] n;
    logic [2:0]    f;
    p   = '0;
    cls = 2'd0;
    err = 1'b1;
    lat = MAX_STEPS + 1;
    for (int v = 1; v <= MAX_STEPS; v++) begin
      n = mtab[p];
      f = n[3:1];
      if (n[0]) begin
        cls = n[5:4]; err = 1'b0; lat = v + 1;
        return;
      end
      if (f > 3'd5) begin
        cls = 2'd0; err = 1'b1; lat = v + 1;
        return;
      end
      p = (xs[f] <= n[11:4]) ? n[11+AW:12] : n[11+2*AW:12+AW];
    end
  endfunction

  always @(posedge clk) begin
    logic v;
    v = busy && (cyc >= hs + lat_e);
    cyc++;
    if (rst) begin
      started = 1'b1;
      busy    = 1'b0;
      rej_e   = 1'b0;
    end else begin
      rej_e = bus.cfg_we && busy;
      if (!busy) begin
        if (bus.cfg_we) mtab[bus.cfg_addr] = bus.cfg_wdata;
        if (bus.in_valid) begin
          xs[0] = bus.X0; xs[1] = bus.X1; xs[2] = bus.X2;
          xs[3] = bus.X3; xs[4] = bus.X4; xs[5] = bus.X5;
          xs[6] = 8'd0;   xs[7] = 8'd0;
          busy = 1'b1;
          hs   = cyc;
          model_run(cls_e, err_e, lat_e);
        end
      end else if (v && bus.out_ready) begin
        busy = 1'b0;
      end
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    logic v;
    if (started) begin
      v = busy && (cyc >= hs + lat_e);
      chk("model_in_ready", 32'(bus.in_ready), 32'(!busy));
      chk("model_out_valid", 32'(bus.out_valid), 32'(v));
      chk("model_cfg_rej", 32'(bus.cfg_rej), 32'(rej_e));
      if (v) begin
        chk("model_out", 32'(bus.out), 32'(cls_e));
        chk("model_out_err", 32'(bus.out_err), 32'(err_e));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int a, input logic [NW-1:0] d);
    bus.cfg_we = 1'b1; bus.cfg_addr = AW'(a); bus.cfg_wdata = d;
    tick();
    bus.cfg_we = 1'b0;
  endtask

  task automatic set_x(input logic [47:0] x);
    {bus.X5, bus.X4, bus.X3, bus.X2, bus.X1, bus.X0} = x;
  endtask

  // mode 0: plain; 1: config write in the handshake cycle; 2: config write during the walk
  task automatic run(input string name, input logic [47:0] x, input int mode, input int ca,
                     input logic [NW-1:0] cd, input int hold, input int eo, input int ee, input int el);
    int k;
    chk({name, "_in_ready_before"}, 32'(bus.in_ready), 32'd1);
    set_x(x);
    bus.in_valid = 1'b1;
    if (mode == 1) begin
      bus.cfg_we = 1'b1; bus.cfg_addr = AW'(ca); bus.cfg_wdata = cd;
    end
    tick();
    bus.in_valid = 1'b0;
    bus.cfg_we   = 1'b0;
    set_x({6{8'h5A}});
    if (mode == 2) begin
      bus.cfg_we = 1'b1; bus.cfg_addr = AW'(ca); bus.cfg_wdata = cd;
    end
    k = 0;
    while (!bus.out_valid && k < 100) begin
      tick();
      k++;
      if (k == 1 && mode == 2) begin
        bus.cfg_we = 1'b0;
        chk({name, "_cfg_rej"}, 32'(bus.cfg_rej), 32'd1);
      end
    end
    chk({name, "_latency"}, 32'(k), 32'(el));
    chk({name, "_out"}, 32'(bus.out), 32'(eo));
    chk({name, "_out_err"}, 32'(bus.out_err), 32'(ee));
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({name, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      chk({name, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
      chk({name, "_hold_out"}, 32'(bus.out), 32'(eo));
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({name, "_idle_after"}, 32'(bus.in_ready), 32'd1);
    chk({name, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
    if (mode == 2) chk({name, "_rej_single"}, 32'(bus.cfg_rej), 32'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.cfg_we = 1'b0;
    bus.cfg_addr = '0;   bus.cfg_wdata = '0;
    set_x('0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out", 32'(bus.out), 32'd0);
    chk("rst_out_err", 32'(bus.out_err), 32'd0);
    chk("rst_cfg_rej", 32'(bus.cfg_rej), 32'd0);

    // Two-leaf tree on X5 with threshold 2
    cfg_write(0, mk_int(5, 2, 1, 2));
    cfg_write(1, mk_leaf(1));
    cfg_write(2, mk_leaf(3));
    run("x5_eq_thr", vec(0, 0, 2),   0, 0, '0, 0, 1, 0, 3);
    run("x5_above",  vec(0, 0, 3),   0, 0, '0, 0, 3, 0, 3);
    run("x5_zero",   vec(0, 0, 0),   0, 0, '0, 5, 1, 0, 3);
    run("x5_max",    vec(0, 0, 255), 0, 0, '0, 0, 3, 0, 3);

    cfg_write(0, mk_leaf(2));
    run("root_leaf", vec(0, 0, 0), 0, 0, '0, 0, 2, 0, 2);
    cfg_write(0, mk_int(6, 0, 1, 2));
    run("feat6", vec(0, 0, 0), 0, 0, '0, 0, 0, 1, 2);
    cfg_write(0, mk_int(7, 0, 1, 2));
    run("feat7", vec(0, 0, 0), 0, 0, '0, 0, 0, 1, 2);
    cfg_write(0, mk_int(0, 0, 0, 0));
    run("step_limit", vec(10, 0, 0), 0, 0, '0, 0, 0, 1, MAX_STEPS + 1);

    // Two-level tree on X0 then X1
    cfg_write(0, mk_int(0, 100, 1, 2));
    cfg_write(1, mk_int(1, 50, 3, 4));
    cfg_write(2, mk_leaf(1));
    cfg_write(3, mk_leaf(0));
    cfg_write(4, mk_leaf(2));
    run("deep_r",   vec(10, 60, 0),  0, 0, '0, 0, 2, 0, 4);
    run("deep_rgt", vec(200, 0, 0),  0, 0, '0, 0, 1, 0, 3);
    run("deep_eq",  vec(100, 50, 0), 0, 0, '0, 0, 0, 0, 4);
    run("walk_cfg", vec(10, 60, 0),  2, 4, mk_leaf(3), 0, 2, 0, 4);
    run("readback", vec(10, 60, 0),  0, 0, '0, 0, 2, 0, 4);
    run("hs_cfg",   vec(200, 0, 0),  1, 2, mk_leaf(0), 0, 0, 0, 3);

    // Reset in the middle of a walk
    set_x(vec(10, 60, 0));
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("midrst_no_valid", 32'(bus.out_valid), 32'd0);
      chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    end
    run("after_rst", vec(10, 60, 0), 0, 0, '0, 0, 2, 0, 4);

    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
